// File: rtl/bp_sacc_pkg.sv
// Shared definitions for the sacc accelerators: CSR offsets, STATUS bits,
// the multi-lane dot-product FSM states and the accelerator-type enum.
package bp_sacc_pkg;

  typedef enum logic [1:0] {
    e_sacc_vdp        = 2'd0,
    e_sacc_scratchpad = 2'd1,
    e_sacc_vdp_mc     = 2'd2
  } bp_sacc_type_e;

  localparam logic [5:0] csr_a_addr_gp = 6'h00;
  localparam logic [5:0] csr_b_addr_gp = 6'h08;
  localparam logic [5:0] csr_len_gp    = 6'h10;
  localparam logic [5:0] csr_start_gp  = 6'h18;
  localparam logic [5:0] csr_status_gp = 6'h20;
  localparam logic [5:0] csr_result_gp = 6'h28;

  localparam int status_busy_bit_gp = 0;
  localparam int status_done_bit_gp = 1;
  localparam int status_err_bit_gp  = 2;

  typedef enum logic [2:0] {
    e_vdp_idle,
    e_vdp_req_a,
    e_vdp_resp_a,
    e_vdp_req_b,
    e_vdp_resp_b,
    e_vdp_mac,
    e_vdp_done
  } vdp_mc_state_e;

endpackage

// File: rtl/bp_sacc_vdp_mc_dp.sv
// Combinational lane-masked multiply-sum: adds the sign-extended products of
// every enabled lane into an acc_width_p-wide sum (wrapping).
module bp_sacc_vdp_mc_dp #(
  parameter int lanes_p      = 4,
  parameter int elem_width_p = 16,
  parameter int acc_width_p  = 64
) (
  input  logic [lanes_p*elem_width_p-1:0] a_beat_i,
  input  logic [lanes_p*elem_width_p-1:0] b_beat_i,
  input  logic [lanes_p-1:0]              mask_i,
  output logic [acc_width_p-1:0]          sum_o
);

  localparam int prod_width_lp = 2 * elem_width_p;

  logic signed [prod_width_lp-1:0] a_ext [lanes_p];
  logic signed [prod_width_lp-1:0] b_ext [lanes_p];
  logic signed [prod_width_lp-1:0] prod  [lanes_p];

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < lanes_p; i++) begin
      a_ext[i] = prod_width_lp'($signed(a_beat_i[i*elem_width_p +: elem_width_p]));
      b_ext[i] = prod_width_lp'($signed(b_beat_i[i*elem_width_p +: elem_width_p]));
      prod[i]  = a_ext[i] * b_ext[i];
      if (mask_i[i]) begin
        sum_o = sum_o + {{(acc_width_p-prod_width_lp){prod[i][prod_width_lp-1]}}, prod[i]};
      end
    end
  end

endmodule

// File: rtl/bp_sacc_vdp_mc.sv
// Multi-lane streaming vector dot-product engine: CSR-programmed, fetches one
// A beat then one B beat per step and accumulates the masked lane products.
module bp_sacc_vdp_mc
  import bp_sacc_pkg::*;
#(
  parameter int lanes_p       = 4,
  parameter int elem_width_p  = 16,
  parameter int paddr_width_p = 40,
  parameter int len_width_p   = 16,
  parameter int acc_width_p   = 64,
  localparam int beat_width_lp = lanes_p * elem_width_p,
  localparam int beat_bytes_lp = beat_width_lp / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     csr_v_i,
  input  logic                     csr_w_i,
  input  logic [5:0]               csr_addr_i,
  input  logic [63:0]              csr_data_i,
  output logic                     csr_ready_o,
  output logic                     csr_resp_v_o,
  output logic [63:0]              csr_resp_data_o,
  input  logic                     csr_resp_yumi_i,
  output logic                     mem_req_v_o,
  output logic [paddr_width_p-1:0] mem_req_addr_o,
  input  logic                     mem_req_yumi_i,
  input  logic                     mem_resp_v_i,
  input  logic [beat_width_lp-1:0] mem_resp_data_i,
  output logic                     mem_resp_ready_o
);

  localparam logic [paddr_width_p-1:0] addr_align_mask_lp = ~paddr_width_p'(beat_bytes_lp - 1);
  localparam logic [paddr_width_p-1:0] beat_step_lp       = paddr_width_p'(beat_bytes_lp);
  localparam logic [len_width_p-1:0]   lanes_len_lp       = len_width_p'(lanes_p);

  vdp_mc_state_e state_r, state_n;

  logic [paddr_width_p-1:0] a_addr_r, b_addr_r, a_ptr_r, b_ptr_r;
  logic [len_width_p-1:0]   len_r, rem_r, rem_next;
  logic [acc_width_p-1:0]   acc_r, dp_sum;
  logic [beat_width_lp-1:0] a_beat_r, b_beat_r;
  logic [lanes_p-1:0]       lane_mask;
  logic                     done_r, err_r, busy;
  logic                     csr_resp_v_r;
  logic [63:0]              csr_resp_data_r, rd_data, status_w;
  logic                     csr_fire, csr_wr, csr_rd, cfg_wr, start_cmd, start_go, status_rd;
  logic                     mem_req_v, mem_resp_ready;
  logic [paddr_width_p-1:0] mem_req_addr;
  logic                     unused_csr_data;

  assign unused_csr_data = ^csr_data_i[63:paddr_width_p];

  // Handshake: a CSR command is taken when csr_v_i & csr_ready_o; its response
  // is held from the next cycle until csr_resp_yumi_i. Memory requests and
  // responses transfer on mem_req_v_o & mem_req_yumi_i / mem_resp_v_i & mem_resp_ready_o.
  assign busy        = (state_r != e_vdp_idle);
  assign csr_ready_o = reset_n_i & ~csr_resp_v_r;
  assign csr_fire    = csr_v_i & csr_ready_o;
  assign csr_wr      = csr_fire & csr_w_i;
  assign csr_rd      = csr_fire & ~csr_w_i;
  assign cfg_wr      = csr_wr & ((csr_addr_i == csr_a_addr_gp) | (csr_addr_i == csr_b_addr_gp)
                                | (csr_addr_i == csr_len_gp));
  assign start_cmd   = csr_wr & (csr_addr_i == csr_start_gp);
  assign start_go    = start_cmd & ~busy;
  assign status_rd   = csr_rd & (csr_addr_i == csr_status_gp);

  assign csr_resp_v_o     = csr_resp_v_r;
  assign csr_resp_data_o  = csr_resp_data_r;
  assign mem_req_v_o      = mem_req_v;
  assign mem_req_addr_o   = mem_req_addr;
  assign mem_resp_ready_o = mem_resp_ready & reset_n_i;

  always_comb begin
    status_w = '0;
    status_w[status_busy_bit_gp] = busy;
    status_w[status_done_bit_gp] = done_r;
    status_w[status_err_bit_gp]  = err_r;
  end

  always_comb begin
    rd_data = '0;
    case (csr_addr_i)
      csr_a_addr_gp: rd_data = 64'(a_addr_r);
      csr_b_addr_gp: rd_data = 64'(b_addr_r);
      csr_len_gp:    rd_data = 64'(len_r);
      csr_status_gp: rd_data = status_w;
      csr_result_gp: rd_data = 64'($signed(acc_r));
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      csr_resp_v_r    <= 1'b0;
      csr_resp_data_r <= '0;
    end else if (csr_fire) begin
      csr_resp_v_r    <= 1'b1;
      csr_resp_data_r <= csr_w_i ? 64'd0 : rd_data;
    end else if (csr_resp_yumi_i) begin
      csr_resp_v_r    <= 1'b0;
    end
  end

  // Lanes at or beyond the remaining count belong to a partial final beat.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < lanes_p; i++) begin
      lane_mask[i] = (rem_r > len_width_p'(i));
    end
    rem_next = (rem_r > lanes_len_lp) ? (rem_r - lanes_len_lp) : '0;
  end

  bp_sacc_vdp_mc_dp #(
    .lanes_p      (lanes_p),
    .elem_width_p (elem_width_p),
    .acc_width_p  (acc_width_p)
  ) dp (
    .a_beat_i (a_beat_r),
    .b_beat_i (b_beat_r),
    .mask_i   (lane_mask),
    .sum_o    (dp_sum)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_vdp_idle;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n        = state_r;
    mem_req_v      = 1'b0;
    mem_req_addr   = '0;
    mem_resp_ready = 1'b0;
    case (state_r)
      e_vdp_idle: begin
        // Stray responses are drained here so they cannot pollute a later beat.
        mem_resp_ready = 1'b1;
        if (start_go) state_n = (len_r == '0) ? e_vdp_done : e_vdp_req_a;
      end
      e_vdp_req_a: begin
        mem_req_v    = 1'b1;
        mem_req_addr = a_ptr_r;
        if (mem_req_yumi_i) state_n = e_vdp_resp_a;
      end
      e_vdp_resp_a: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_v_i) state_n = e_vdp_req_b;
      end
      e_vdp_req_b: begin
        mem_req_v    = 1'b1;
        mem_req_addr = b_ptr_r;
        if (mem_req_yumi_i) state_n = e_vdp_resp_b;
      end
      e_vdp_resp_b: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_v_i) state_n = e_vdp_mac;
      end
      e_vdp_mac:  state_n = (rem_next != '0) ? e_vdp_req_a : e_vdp_done;
      e_vdp_done: state_n = e_vdp_idle;
      default:    state_n = e_vdp_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_addr_r <= '0;
      b_addr_r <= '0;
      len_r    <= '0;
      a_ptr_r  <= '0;
      b_ptr_r  <= '0;
      rem_r    <= '0;
      acc_r    <= '0;
      a_beat_r <= '0;
      b_beat_r <= '0;
    end else begin
      if (cfg_wr && !busy) begin
        case (csr_addr_i)
          csr_a_addr_gp: a_addr_r <= csr_data_i[paddr_width_p-1:0] & addr_align_mask_lp;
          csr_b_addr_gp: b_addr_r <= csr_data_i[paddr_width_p-1:0] & addr_align_mask_lp;
          csr_len_gp:    len_r    <= csr_data_i[len_width_p-1:0];
          default: ;
        endcase
      end
      if (start_go) begin
        a_ptr_r <= a_addr_r;
        b_ptr_r <= b_addr_r;
        rem_r   <= len_r;
        acc_r   <= '0;
      end
      if (state_r == e_vdp_resp_a && mem_resp_v_i) a_beat_r <= mem_resp_data_i;
      if (state_r == e_vdp_resp_b && mem_resp_v_i) b_beat_r <= mem_resp_data_i;
      if (state_r == e_vdp_mac) begin
        acc_r   <= acc_r + dp_sum;
        a_ptr_r <= a_ptr_r + beat_step_lp;
        b_ptr_r <= b_ptr_r + beat_step_lp;
        rem_r   <= rem_next;
      end
    end
  end

  // Completion wins over a same-cycle STATUS read, which returned done=0.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if (state_r == e_vdp_done)    done_r <= 1'b1;
      else if (start_go || status_rd) done_r <= 1'b0;

      if (start_go)                            err_r <= 1'b0;
      else if ((cfg_wr || start_cmd) && busy)  err_r <= 1'b1;
      else if (status_rd)                      err_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_sacc_vdp_mc.sv
// Randomised bench for bp_sacc_vdp_mc: CSR scoreboard plus a beat memory model,
// with expected results computed element by element from the memory contents.
module tb_bp_sacc_vdp_mc;
  import bp_sacc_pkg::*;

  localparam int lanes_lp = 4;
  localparam int ew_lp    = 16;
  localparam int pw_lp    = 40;
  localparam int bw_lp    = lanes_lp * ew_lp;
  localparam int bb_lp    = bw_lp / 8;

  logic              clk = 1'b0;
  logic              reset_n_i;
  logic              csr_v_i, csr_w_i;
  logic [5:0]        csr_addr_i;
  logic [63:0]       csr_data_i;
  logic              csr_ready_o, csr_resp_v_o, csr_resp_yumi_i;
  logic [63:0]       csr_resp_data_o;
  logic              mem_req_v_o, mem_req_yumi_i, mem_resp_v_i, mem_resp_ready_o;
  logic [pw_lp-1:0]  mem_req_addr_o;
  logic [bw_lp-1:0]  mem_resp_data_i;

  bp_sacc_vdp_mc #(
    .lanes_p(lanes_lp), .elem_width_p(ew_lp), .paddr_width_p(pw_lp),
    .len_width_p(16), .acc_width_p(64)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .csr_v_i(csr_v_i), .csr_w_i(csr_w_i), .csr_addr_i(csr_addr_i), .csr_data_i(csr_data_i),
    .csr_ready_o(csr_ready_o), .csr_resp_v_o(csr_resp_v_o), .csr_resp_data_o(csr_resp_data_o),
    .csr_resp_yumi_i(csr_resp_yumi_i),
    .mem_req_v_o(mem_req_v_o), .mem_req_addr_o(mem_req_addr_o), .mem_req_yumi_i(mem_req_yumi_i),
    .mem_resp_v_i(mem_resp_v_i), .mem_resp_data_i(mem_resp_data_i), .mem_resp_ready_o(mem_resp_ready_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0]      exp_q[$];
  string            name_q[$];
  logic [pw_lp-1:0] exp_addr_q[$];
  logic [bw_lp-1:0] pend_q[$];
  logic [bw_lp-1:0] mem [logic [pw_lp-1:0]];
  int               resp_budget = -1;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(string nm, string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", nm, why);
  endfunction

  // reference memory model: element k of a vector lives in beat k/lanes, lane k%lanes
  function automatic logic [pw_lp-1:0] elem_beat(logic [pw_lp-1:0] base, int k);
    return (base & ~pw_lp'(bb_lp - 1)) + pw_lp'((k / lanes_lp) * bb_lp);
  endfunction

  function automatic logic [bw_lp-1:0] mem_rd(logic [pw_lp-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 64'hDEAD_BEEF_0BAD_F00D;
  endfunction

  function automatic logic [ew_lp-1:0] get_elem(logic [pw_lp-1:0] base, int k);
    logic [bw_lp-1:0] beat;
    beat = mem_rd(elem_beat(base, k));
    return beat[(k % lanes_lp)*ew_lp +: ew_lp];
  endfunction

  task automatic put_elem(input logic [pw_lp-1:0] base, input int k, input logic [ew_lp-1:0] v);
    logic [pw_lp-1:0] ba;
    logic [bw_lp-1:0] beat;
    ba = elem_beat(base, k);
    beat = mem.exists(ba) ? mem[ba] : {$urandom, $urandom};
    beat[(k % lanes_lp)*ew_lp +: ew_lp] = v;
    mem[ba] = beat;
  endtask

  function automatic logic [63:0] ref_dot(logic [pw_lp-1:0] a, logic [pw_lp-1:0] b, int n);
    longint acc = 0;
    for (int k = 0; k < n; k++)
      acc += longint'($signed(get_elem(a, k))) * longint'($signed(get_elem(b, k)));
    return 64'(acc);
  endfunction

  // scoreboard monitor for CSR responses
  always @(negedge clk) begin
    csr_resp_yumi_i = ($urandom_range(0, 3) != 0);
    if (reset_n_i && csr_resp_v_o && csr_resp_yumi_i) begin
      if (exp_q.size() == 0) fail_now("csr_unexpected_resp", $sformatf("got 0x%0h, none required", csr_resp_data_o));
      else check(name_q.pop_front(), csr_resp_data_o, exp_q.pop_front());
    end
  end

  // memory responder and request-address scoreboard
  always @(negedge clk) begin
    mem_req_yumi_i = ($urandom_range(0, 3) != 0);
    if (reset_n_i && mem_req_v_o && mem_req_yumi_i) begin
      if (exp_addr_q.size() == 0)
        fail_now("mem_req_unexpected", $sformatf("got addr 0x%0h, no request required", mem_req_addr_o));
      else
        check("mem_req_addr", 64'(mem_req_addr_o), 64'(exp_addr_q.pop_front()));
      pend_q.push_back(mem_rd(mem_req_addr_o));
    end
    if (pend_q.size() > 0 && resp_budget != 0 && $urandom_range(0, 2) != 0) begin
      mem_resp_v_i    = 1'b1;
      mem_resp_data_i = pend_q[0];
    end else begin
      mem_resp_v_i    = 1'b0;
      mem_resp_data_i = {$urandom, $urandom};
    end
    if (reset_n_i && mem_resp_v_i && mem_resp_ready_o) begin
      void'(pend_q.pop_front());
      if (resp_budget > 0) resp_budget--;
    end
  end

  // driver tasks
  task automatic csr_op(input bit w, input logic [5:0] adr, input logic [63:0] d,
                        input logic [63:0] e, input string nm);
    int n = 0;
    @(negedge clk);
    while (!csr_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail_now({nm, "_ready_timeout"}, "csr_ready_o stayed 0 for 200 cycles, required 1");
    end else begin
      csr_v_i = 1'b1; csr_w_i = w; csr_addr_i = adr; csr_data_i = d;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      csr_v_i = 1'b0;
      csr_data_i = {$urandom, $urandom};
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((exp_addr_q.size() != 0 || pend_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      fail_now({nm, "_timeout"}, $sformatf("%0d requests and %0d responses still outstanding, required 0",
               exp_addr_q.size(), pend_q.size()));
      exp_addr_q.delete();
      pend_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic setup_op(input logic [pw_lp-1:0] a, input logic [pw_lp-1:0] b, input int n);
    csr_op(1'b1, csr_a_addr_gp, 64'(a), 64'd0, "wr_a_addr");
    csr_op(1'b1, csr_b_addr_gp, 64'(b), 64'd0, "wr_b_addr");
    csr_op(1'b1, csr_len_gp, 64'(n), 64'd0, "wr_len");
    for (int j = 0; j < (n + lanes_lp - 1) / lanes_lp; j++) begin
      exp_addr_q.push_back((a & ~pw_lp'(bb_lp - 1)) + pw_lp'(j * bb_lp));
      exp_addr_q.push_back((b & ~pw_lp'(bb_lp - 1)) + pw_lp'(j * bb_lp));
    end
  endtask

  task automatic run_op(input string nm, input logic [pw_lp-1:0] a, input logic [pw_lp-1:0] b,
                        input int n, input logic [63:0] exp_res);
    setup_op(a, b, n);
    csr_op(1'b1, csr_start_gp, 64'd0, 64'd0, "wr_start");
    wait_done(nm);
    csr_op(1'b0, csr_result_gp, 64'd0, exp_res, {nm, "_result"});
    csr_op(1'b0, csr_status_gp, 64'd0, 64'h2, {nm, "_status"});
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_csr_ready"}, 64'(csr_ready_o), 64'd0);
    check({nm, "_csr_resp_v"}, 64'(csr_resp_v_o), 64'd0);
    check({nm, "_csr_resp_data"}, csr_resp_data_o, 64'd0);
    check({nm, "_mem_req_v"}, 64'(mem_req_v_o), 64'd0);
    check({nm, "_mem_req_addr"}, 64'(mem_req_addr_o), 64'd0);
    check({nm, "_mem_resp_ready"}, 64'(mem_resp_ready_o), 64'd0);
  endtask

  initial begin
    csr_v_i = 1'b0; csr_w_i = 1'b0; csr_addr_i = '0; csr_data_i = '0;
    csr_resp_yumi_i = 1'b0; mem_req_yumi_i = 1'b0; mem_resp_v_i = 1'b0; mem_resp_data_i = '0;
    reset_n_i = 1'b1;
    #3 reset_n_i = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    #2 reset_n_i = 1'b1;

    csr_op(1'b0, csr_status_gp, 64'd0, 64'd0, "status_after_reset");
    csr_op(1'b0, 6'h30, 64'd0, 64'd0, "unmapped_read");

    // 4-element dot product, B base deliberately unaligned
    for (int k = 0; k < 4; k++) begin
      put_elem(40'h1000, k, 16'(k + 1));
      put_elem(40'h2000, k, 16'(k + 5));
    end
    run_op("dot4", 40'h1000, 40'h2003, 4, 64'd70);
    csr_op(1'b0, csr_status_gp, 64'd0, 64'd0, "status_cleared");
    csr_op(1'b0, csr_b_addr_gp, 64'd0, 64'h2000, "b_addr_aligned");
    csr_op(1'b1, 6'h38, 64'hFFFF, 64'd0, "wr_unmapped");
    csr_op(1'b0, csr_len_gp, 64'd0, 64'd4, "len_readback");

    // partial final beat: lanes holding 9 must be masked
    for (int k = 0; k < 8; k++) begin
      put_elem(40'h3000, k, (k < 4) ? 16'd1 : ((k < 6) ? 16'd2 : 16'd9));
      put_elem(40'h4000, k, 16'd3);
    end
    run_op("dot6_masked", 40'h3000, 40'h4000, 6, 64'd24);

    // zero length: done without traffic, result cleared
    csr_op(1'b1, csr_len_gp, 64'd0, 64'd0, "wr_len0");
    csr_op(1'b1, csr_start_gp, 64'd0, 64'd0, "wr_start_len0");
    csr_op(1'b0, csr_status_gp, 64'd0, 64'h2, "len0_status");
    csr_op(1'b0, csr_result_gp, 64'd0, 64'd0, "len0_result");

    // signed extremes
    for (int k = 0; k < 4; k++) begin
      put_elem(40'h5000, k, 16'h8000);
      put_elem(40'h6000, k, 16'h8000);
      put_elem(40'h7000, k, 16'hFFFF);
      put_elem(40'h8000, k, 16'h0001);
    end
    run_op("min_sq", 40'h5000, 40'h6000, 4, 64'd4294967296);
    run_op("neg4", 40'h7000, 40'h8000, 4, 64'hFFFF_FFFF_FFFF_FFFC);

    // commands while busy are dropped and flag err
    for (int k = 0; k < 8; k++) begin
      put_elem(40'h9000, k, 16'($urandom));
      put_elem(40'hA000, k, 16'($urandom));
    end
    resp_budget = 0;
    setup_op(40'h9000, 40'hA000, 8);
    csr_op(1'b1, csr_start_gp, 64'd0, 64'd0, "busy_start");
    csr_op(1'b1, csr_len_gp, 64'd3, 64'd0, "busy_wr_len");
    csr_op(1'b1, csr_start_gp, 64'd0, 64'd0, "busy_restart");
    csr_op(1'b1, csr_a_addr_gp, 64'h5555, 64'd0, "busy_wr_a");
    resp_budget = -1;
    wait_done("busy");
    csr_op(1'b0, csr_result_gp, 64'd0, ref_dot(40'h9000, 40'hA000, 8), "busy_result");
    csr_op(1'b0, csr_status_gp, 64'd0, 64'h6, "busy_status_err");
    csr_op(1'b0, csr_status_gp, 64'd0, 64'h0, "busy_status_cleared");
    csr_op(1'b0, csr_len_gp, 64'd0, 64'd8, "busy_len_kept");
    csr_op(1'b0, csr_a_addr_gp, 64'd0, 64'h9000, "busy_a_kept");

    // randomised operations, some wrapping past the top of the address space
    for (int t = 0; t < 12; t++) begin
      logic [pw_lp-1:0] a, b;
      int n;
      a = pw_lp'({$urandom, $urandom});
      b = pw_lp'({$urandom, $urandom});
      if (t % 4 == 3) a = 40'hFF_FFFF_FFF0 | pw_lp'($urandom_range(0, 15));
      n = $urandom_range(0, 20);
      for (int k = 0; k < n; k++) begin
        put_elem(a, k, 16'($urandom));
        put_elem(b, k, 16'($urandom));
      end
      run_op($sformatf("rand%0d", t), a, b, n, ref_dot(a, b, n));
    end

    // reset while waiting for the B beat
    resp_budget = 1;
    setup_op(40'h1000, 40'h2000, 4);
    csr_op(1'b1, csr_start_gp, 64'd0, 64'd0, "rst_start");
    begin
      int n = 0;
      while (exp_addr_q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (n >= 500) fail_now("rst_reach_resp_b", "B request not taken within 500 cycles");
    end
    repeat (2) @(negedge clk);
    #2 reset_n_i = 1'b0;
    #1 check_reset_outputs("mid_op_reset");
    exp_q.delete(); name_q.delete(); exp_addr_q.delete(); pend_q.delete();
    resp_budget = -1;
    repeat (2) @(negedge clk);
    #2 reset_n_i = 1'b1;
    @(negedge clk);
    #1 pend_q.push_back({$urandom, $urandom});
    begin
      int n = 0;
      while (pend_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) fail_now("stale_resp_drain", "stale response not accepted in IDLE within 200 cycles");
    end
    csr_op(1'b0, csr_status_gp, 64'd0, 64'd0, "post_reset_status");
    csr_op(1'b0, csr_result_gp, 64'd0, 64'd0, "post_reset_result");
    csr_op(1'b0, csr_a_addr_gp, 64'd0, 64'd0, "post_reset_a_addr");
    run_op("post_reset_dot4", 40'h1000, 40'h2000, 4, 64'd70);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) fail_now("final_drain", $sformatf("%0d CSR responses missing, required 0", exp_q.size()));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
